// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the requester count and IDs, the address width, the FSM state
// encoding, the default memory depth, and a one-hot to index helper.
package dm_arb_pkg;

    localparam int NUM_REQ       = 4;
    localparam int ADDR_W        = 9;
    localparam int MEM_DEPTH_DEF = 400;

    // Requester IDs (bit positions in req/we/lock/gnt/done)
    localparam int REQ_REGS   = 0;
    localparam int REQ_ACC    = 1;
    localparam int REQ_STACK  = 2;
    localparam int REQ_CRYPTO = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Convert a one-hot requester vector to its index (0 when empty).
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req    in  4  request vector
//   ptr    in  2  highest-priority requester index for this pick
//   winner out 4  one-hot winner (zero when no request)
//   valid  out 1  at least one request present
module rr_picker
    import dm_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    // Scan ptr, ptr+1, ... (mod 4) and take the first active request.
    always_comb begin
        logic [1:0] idx;
        idx    = 2'd0;
        winner = 4'b0000;
        valid  = |req;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + 2'(k);
            if ((winner == 4'b0000) && req[idx]) begin
                winner[idx] = 1'b1;
            end else begin
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbiter granting four requesters single-word access to a data memory.
// One access is in flight at a time: IDLE -> ACCESS (gnt) -> DONE (done).
// A requester holding lock may chain up to MAX_LOCK accesses, skipping IDLE.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req/we/lock      per-requester request, write qualifier, bus hold
//   addr, wdata      packed per-requester address and write data
//   gnt, done        one-hot grant / completion pulses
//   rdata, err       read data and out-of-range flag, valid with done
//   mem_addr/we/wdata/rdata  data memory port (mem_rdata combinational)
module data_mem_arbiter
    import dm_arb_pkg::*;
#(
    parameter int WIDTH     = 15,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int MAX_LOCK  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           we,
    input  logic [NUM_REQ-1:0]           lock,
    input  logic [NUM_REQ*ADDR_W-1:0]    addr,
    input  logic [NUM_REQ*(WIDTH+1)-1:0] wdata,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [WIDTH:0]               rdata,
    output logic                         err,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_we,
    output logic [WIDTH:0]               mem_wdata,
    input  logic [WIDTH:0]               mem_rdata
);

    localparam int                 LCW       = $clog2(MAX_LOCK) + 1;
    localparam logic [LCW-1:0]     LOCK_LAST = LCW'(MAX_LOCK - 1);
    localparam logic [ADDR_W:0]    DEPTH_C   = (ADDR_W + 1)'(MEM_DEPTH);

    state_e               state_r;
    logic [1:0]           ptr_r;
    logic [LCW-1:0]       lock_cnt_r;
    logic [NUM_REQ-1:0]   win_r;
    logic                 we_r;

    logic [NUM_REQ-1:0]   pick_s;
    logic                 pick_valid_s;
    logic [1:0]           sel_idx_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic                 sel_we_s;
    logic [WIDTH:0]       sel_wdata_s;
    logic                 sel_in_range_s;
    logic                 cur_in_range_s;
    logic                 lock_go_s;

    rr_picker u_picker (
        .req    (req),
        .ptr    (ptr_r),
        .winner (pick_s),
        .valid  (pick_valid_s)
    );

    // Select whose inputs get latched: the fresh RR pick from IDLE, or the
    // current winner when a locked burst continues out of DONE.
    always_comb begin
        if (state_r == ST_DONE) begin
            sel_idx_s = onehot_to_idx(win_r);
        end else begin
            sel_idx_s = onehot_to_idx(pick_s);
        end
        sel_addr_s     = addr[int'(sel_idx_s) * ADDR_W +: ADDR_W];
        sel_we_s       = we[sel_idx_s];
        sel_wdata_s    = wdata[int'(sel_idx_s) * (WIDTH + 1) +: (WIDTH + 1)];
        sel_in_range_s = ({1'b0, sel_addr_s} < DEPTH_C);
        cur_in_range_s = ({1'b0, mem_addr} < DEPTH_C);
        lock_go_s      = (|(lock & win_r)) && (|(req & win_r)) &&
                         (lock_cnt_r < LOCK_LAST);
    end

    // FSM, pointer, lock counter and registered outputs. Pulses default to
    // zero every cycle and are raised only on entry to ACCESS/DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 2'd0;
            lock_cnt_r <= '0;
            win_r      <= 4'b0000;
            we_r       <= 1'b0;
            gnt        <= 4'b0000;
            done       <= 4'b0000;
            rdata      <= '0;
            err        <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            gnt    <= 4'b0000;
            done   <= 4'b0000;
            mem_we <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        win_r     <= pick_s;
                        we_r      <= sel_we_s;
                        gnt       <= pick_s;
                        mem_addr  <= sel_addr_s;
                        mem_wdata <= sel_wdata_s;
                        mem_we    <= sel_we_s & sel_in_range_s;
                        state_r   <= ST_ACCESS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    done  <= win_r;
                    err   <= ~cur_in_range_s;
                    // Writes and out-of-range reads return zero.
                    if (!we_r && cur_in_range_s) begin
                        rdata <= mem_rdata;
                    end else begin
                        rdata <= '0;
                    end
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    if (lock_go_s) begin
                        we_r       <= sel_we_s;
                        gnt        <= win_r;
                        mem_addr   <= sel_addr_s;
                        mem_wdata  <= sel_wdata_s;
                        mem_we     <= sel_we_s & sel_in_range_s;
                        lock_cnt_r <= lock_cnt_r + LCW'(1);
                        state_r    <= ST_ACCESS;
                    end else begin
                        lock_cnt_r <= '0;
                        ptr_r      <= onehot_to_idx(win_r) + 2'd1;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a 512-word memory
// model (combinational read, clocked write, preload port for setup).
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [3:0]  lock;
    logic [35:0] addr;
    logic [63:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [15:0] rdata;
    logic        err;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] mem [0:511];
    logic        pre_en;
    logic [8:0]  pre_addr;
    logic [15:0] pre_data;

    int checks;
    int errors;

    data_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [8:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        cycle();
        pre_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0; we = 4'b0; lock = 4'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        preload(9'd5, 16'hAAAA);
        preload(9'd450, 16'h1234);
        preload(9'd7, 16'h0000);
        preload(9'd30, 16'hC0DE);
        for (int k = 0; k < 4; k++) preload(9'd10 + 9'(k), 16'h1000 + 16'(k));
        checks++;
        if ({gnt, done, err, mem_we} !== 10'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 0", {gnt, done, err, mem_we});
        end
        checks++;
        if ({rdata, mem_addr, mem_wdata} !== 41'b0) begin
            errors++; $display("FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h expected 0", rdata, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_single_read();
        req = 4'b0001; we = 4'b0000; addr[8:0] = 9'd5;
        cycle();
        checks++;
        if (gnt !== 4'b0001 || mem_we !== 1'b0 || mem_addr !== 9'd5) begin
            errors++; $display("FAIL read_gnt: gnt=%b mem_we=%b mem_addr=%0d expected 0001/0/5", gnt, mem_we, mem_addr);
        end
        req = 4'b0000;
        cycle();
        checks++;
        if (done !== 4'b0001 || rdata !== 16'hAAAA || err !== 1'b0 || gnt !== 4'b0000) begin
            errors++; $display("FAIL read_done: done=%b rdata=%h err=%b gnt=%b expected 0001/aaaa/0/0000", done, rdata, err, gnt);
        end
        cycle();
        checks++;
        if (done !== 4'b0000 || gnt !== 4'b0000) begin
            errors++; $display("FAIL read_idle: done=%b gnt=%b expected 0", done, gnt);
        end
    endtask

    task automatic test_all_four();
        logic [3:0] exp_oh;
        do_reset();
        req = 4'b1111; we = 4'b0000;
        addr = {9'd13, 9'd12, 9'd11, 9'd10};
        for (int k = 0; k < 4; k++) begin
            exp_oh = 4'b0001 << k;
            cycle();
            checks++;
            if (gnt !== exp_oh) begin
                errors++; $display("FAIL rr_gnt%0d: gnt=%b expected %b", k, gnt, exp_oh);
            end
            req = req & ~exp_oh;
            cycle();
            checks++;
            if (done !== exp_oh || rdata !== (16'h1000 + 16'(k))) begin
                errors++; $display("FAIL rr_done%0d: done=%b rdata=%h expected %b/%h", k, done, rdata, exp_oh, 16'h1000 + 16'(k));
            end
            cycle();
            checks++;
            if (gnt !== 4'b0000) begin
                errors++; $display("FAIL rr_gap%0d: gnt=%b expected 0000", k, gnt);
            end
        end
    endtask

    task automatic test_writes();
        // Out-of-range write from requester 1 (ptr is 0 here).
        req = 4'b0010; we = 4'b0010; addr[17:9] = 9'd450; wdata[31:16] = 16'h5555;
        cycle();
        checks++;
        if (gnt !== 4'b0010 || mem_we !== 1'b0 || mem_addr !== 9'd450) begin
            errors++; $display("FAIL oor_gnt: gnt=%b mem_we=%b mem_addr=%0d expected 0010/0/450", gnt, mem_we, mem_addr);
        end
        req = 4'b0000;
        cycle();
        checks++;
        if (done !== 4'b0010 || err !== 1'b1 || rdata !== 16'h0000) begin
            errors++; $display("FAIL oor_done: done=%b err=%b rdata=%h expected 0010/1/0000", done, err, rdata);
        end
        cycle();
        checks++;
        if (mem[450] !== 16'h1234 || err !== 1'b0) begin
            errors++; $display("FAIL oor_nowrite: mem450=%h err=%b expected 1234/0", mem[450], err);
        end
        // In-range write from requester 2.
        req = 4'b0100; we = 4'b0100; addr[26:18] = 9'd7; wdata[47:32] = 16'hBEEF;
        cycle();
        checks++;
        if (gnt !== 4'b0100 || mem_we !== 1'b1 || mem_wdata !== 16'hBEEF) begin
            errors++; $display("FAIL wr_gnt: gnt=%b mem_we=%b mem_wdata=%h expected 0100/1/beef", gnt, mem_we, mem_wdata);
        end
        req = 4'b0000; we = 4'b0000;
        cycle();
        checks++;
        if (done !== 4'b0100 || rdata !== 16'h0000 || err !== 1'b0 || mem_we !== 1'b0 || mem[7] !== 16'hBEEF) begin
            errors++; $display("FAIL wr_done: done=%b rdata=%h err=%b mem_we=%b mem7=%h expected 0100/0000/0/0/beef", done, rdata, err, mem_we, mem[7]);
        end
        cycle();
    endtask

    task automatic test_reset_in_access();
        req = 4'b0010; we = 4'b0010; addr[17:9] = 9'd20; wdata[31:16] = 16'h7777;
        cycle();
        checks++;
        if (gnt !== 4'b0010 || mem_we !== 1'b1) begin
            errors++; $display("FAIL rst_acc_gnt: gnt=%b mem_we=%b expected 0010/1", gnt, mem_we);
        end
        req = 4'b0000; we = 4'b0000; rst = 1'b1;
        cycle();
        checks++;
        if (done !== 4'b0000 || mem_we !== 1'b0 || gnt !== 4'b0000 || mem_addr !== 9'd0) begin
            errors++; $display("FAIL rst_acc_drop: done=%b mem_we=%b gnt=%b mem_addr=%0d expected 0", done, mem_we, gnt, mem_addr);
        end
        rst = 1'b0;
        req = 4'b0100; addr[26:18] = 9'd5;
        cycle();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++; $display("FAIL rst_acc_regnt: gnt=%b expected 0100", gnt);
        end
        req = 4'b0000;
        cycle();
        checks++;
        if (done !== 4'b0100 || rdata !== 16'hAAAA) begin
            errors++; $display("FAIL rst_acc_done: done=%b rdata=%h expected 0100/aaaa", done, rdata);
        end
        cycle();
    endtask

    task automatic test_lock();
        // ptr is 3 after requester 2 was served.
        req = 4'b1001; we = 4'b0000; lock = 4'b1000;
        addr[35:27] = 9'd30; addr[8:0] = 9'd5;
        for (int g = 0; g < 4; g++) begin
            cycle();
            checks++;
            if (gnt !== 4'b1000) begin
                errors++; $display("FAIL lock_gnt%0d: gnt=%b expected 1000", g, gnt);
            end
            cycle();
            checks++;
            if (done !== 4'b1000 || rdata !== 16'hC0DE) begin
                errors++; $display("FAIL lock_done%0d: done=%b rdata=%h expected 1000/c0de", g, done, rdata);
            end
        end
        cycle();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL lock_release: gnt=%b expected 0000", gnt);
        end
        cycle();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL lock_next: gnt=%b expected 0001", gnt);
        end
        req = 4'b0000; lock = 4'b0000;
        cycle();
        checks++;
        if (done !== 4'b0001 || rdata !== 16'hAAAA) begin
            errors++; $display("FAIL lock_next_done: done=%b rdata=%h expected 0001/aaaa", done, rdata);
        end
        cycle();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; req = 4'b0; we = 4'b0; lock = 4'b0;
        addr = '0; wdata = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        cycle();
        test_reset();
        test_single_read();
        test_all_four();
        test_writes();
        test_reset_in_access();
        test_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
